fht_frame_seq: RTL and testbench
================================

FHT_FRAME_SEQ -- requirements
Module: fht_frame_seq

Interface
REQ-001 SHALL have parameter D_BIT, default 22, data word width (fixed-point, same format as fht_top).
REQ-002 SHALL have parameter A_BIT, default 8, bank address width; N = 2**A_BIT words per bank; frame = 4*N words.
REQ-003 SHALL have port iCLK  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port iRESET  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports iVALID in 1, iDATA in D_BIT, oREADY out 1: input sample stream.
REQ-006 SHALL have ports oWE out 4 (one-hot bank write enable), oADDR_WR out A_BIT, oDATA_WR out D_BIT: core RAM write side.
REQ-007 SHALL have port oSTART  out  1  one-cycle start pulse to core.
REQ-008 SHALL have port iRDY_CORE  in  1  core done/ready level (fht_top oRDY).
REQ-009 SHALL have ports oADDR_RD out A_BIT and iDATA_RD_0..3 in D_BIT each: core read side, 1-cycle read latency.
REQ-010 SHALL have ports oVALID out 1, oDATA out D_BIT, iREADY in 1: output result stream.
REQ-011 SHALL have port oBUSY  out  1  high from first accepted sample until last result accepted.

Function
REQ-012 SHALL implement states LOAD, START, WAIT, UNLOAD; reset state LOAD.
REQ-013 LOAD: oREADY=1; each accepted sample k (iVALID&oREADY) SHALL drive oWE[k mod 4]=1, oADDR_WR=k/4, oDATA_WR=iDATA in the same cycle (combinational from registered counter).
REQ-014 Sample counter SHALL be A_BIT+2 bits; acceptance of k=4N-1 SHALL transition to START; counter wraps to 0.
REQ-015 START: oSTART=1 for exactly one cycle, oREADY=0; next state WAIT.
REQ-016 WAIT SHALL ignore iRDY_CORE for the first 2 cycles, then move to UNLOAD on the first cycle iRDY_CORE=1 (tolerates stale high level from previous frame).
REQ-017 UNLOAD SHALL emit 4N words in order: for j=0..N-1, for b=0..3: bank b at address bitrev(j) (A_BIT-bit reversal).
REQ-018 Read pipeline: oADDR_RD registered; data from iDATA_RD_b captured one cycle after address issue into a 2-entry output skid buffer.
REQ-019 A read SHALL be issued only if buffer occupancy + in-flight reads < 2; with iREADY held 1, throughput SHALL be one word per cycle after 2-cycle initial latency.
REQ-020 oVALID = buffer non-empty; oDATA = buffer head; word SHALL be held stable while oVALID&!iREADY.
REQ-021 After the 4N-th word is accepted, SHALL return to LOAD next cycle; oBUSY deasserts same cycle.
REQ-022 oREADY SHALL be 0 in START, WAIT, UNLOAD; iVALID there SHALL be ignored (no write).
REQ-023 oWE SHALL never have more than one bit set; oWE=0 outside LOAD handshakes.
REQ-024 iRDY_CORE toggling during LOAD/UNLOAD SHALL have no effect.

Reset
REQ-025 iRESET=0 SHALL asynchronously force: state LOAD, counters 0, buffer empty, oWE=0, oSTART=0, oVALID=0, oBUSY=0, oADDR_WR=0, oADDR_RD=0, oDATA=0; oREADY=1 one cycle after release.
REQ-026 Reset mid-frame (any state) SHALL discard partial frame; next frame starts at bank 0, address 0.

Verification (A_BIT=2, N=4, frame 16)
REQ-027 Stream samples 0..15 back-to-back -> oWE cycles 1,2,4,8 repeating; oADDR_WR 0,0,0,0,1,...,3; START pulse exactly 1 cycle after sample 15.
REQ-028 iRDY_CORE held 1 throughout -> UNLOAD entered no earlier than 3 cycles after oSTART.
REQ-029 Core RAM b[a]=16*b+a, iREADY=1 -> output 0,16,32,48,2,18,34,50,1,17,33,49,3,19,35,51 on 16 consecutive cycles.
REQ-030 iREADY random 50% -> same 16-word sequence, no loss/duplication, oDATA stable while stalled.
REQ-031 iVALID gaps during LOAD -> addresses/banks unaffected by gaps; iVALID during WAIT -> no oWE.
REQ-032 Assert iRESET low during UNLOAD after 5 words -> all outputs zero immediately; following fresh frame loads and unloads correctly.

Source files
------------

// File: rtl/fht_frame_seq.sv
// Frame sequencer for the FHT core.
// Loads 4N input samples round-robin into the four core banks, pulses the
// core start, waits for the core to finish, then streams the results back
// out in bit-reversed address order through a 2-entry skid buffer.
module fht_frame_seq #(
  parameter int D_BIT = 22,
  parameter int A_BIT = 8
) (
  input  logic             iCLK,
  input  logic             iRESET,
  // input sample stream
  input  logic             iVALID,
  input  logic [D_BIT-1:0] iDATA,
  output logic             oREADY,
  // core RAM write side
  output logic [3:0]       oWE,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [D_BIT-1:0] oDATA_WR,
  // core control
  output logic             oSTART,
  input  logic             iRDY_CORE,
  // core RAM read side
  output logic [A_BIT-1:0] oADDR_RD,
  input  logic [D_BIT-1:0] iDATA_RD_0,
  input  logic [D_BIT-1:0] iDATA_RD_1,
  input  logic [D_BIT-1:0] iDATA_RD_2,
  input  logic [D_BIT-1:0] iDATA_RD_3,
  // result stream
  output logic             oVALID,
  output logic [D_BIT-1:0] oDATA,
  input  logic             iREADY,
  output logic             oBUSY
);

  // Frame counters index {address, bank}: low two bits select the bank.
  localparam int CW = A_BIT + 2;
  localparam logic [CW-1:0] LAST = {CW{1'b1}};

  typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_UNLOAD} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [1:0]       wait_cnt_q, wait_cnt_d;
  logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
  logic             iss_done_q, iss_done_d;
  logic [CW-1:0]    pop_cnt_q, pop_cnt_d;
  logic             infl_q, infl_d;
  logic [1:0]       infl_bank_q, infl_bank_d;
  logic [A_BIT-1:0] addr_rd_q, addr_rd_d;
  logic [1:0]       occ_q, occ_d;
  logic             wptr_q, wptr_d;
  logic             rptr_q, rptr_d;
  logic             rdy_en_q;
  logic [D_BIT-1:0] buf_q [2];

  logic             accept;
  logic             pop;
  logic             issue;
  logic [2:0]       ahead;
  logic [D_BIT-1:0] rd_data;

  function automatic logic [A_BIT-1:0] bitrev(input logic [A_BIT-1:0] v);
    logic [A_BIT-1:0] r;
    for (int i = 0; i < A_BIT; i++) r[i] = v[A_BIT-1-i];
    return r;
  endfunction

  // Handshakes and read-issue decision; a pop this cycle frees a slot, which
  // keeps one word per cycle flowing with only two buffer entries.
  always_comb begin
    accept  = oREADY & iVALID;
    pop     = oVALID & iREADY;
    ahead   = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    issue   = (state_q == S_UNLOAD) && !iss_done_q && (ahead < 3'd2);
    unique case (infl_bank_q)
      2'd0:    rd_data = iDATA_RD_0;
      2'd1:    rd_data = iDATA_RD_1;
      2'd2:    rd_data = iDATA_RD_2;
      default: rd_data = iDATA_RD_3;
    endcase
  end

  // Next-state logic for the FSM, counters, read pipeline and skid buffer.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    iss_done_d  = iss_done_q;
    pop_cnt_d   = pop_cnt_q;
    infl_d      = 1'b0;
    infl_bank_d = infl_bank_q;
    addr_rd_d   = addr_rd_q;
    occ_d       = occ_q + {1'b0, infl_q} - {1'b0, pop};
    wptr_d      = wptr_q ^ infl_q;
    rptr_d      = rptr_q ^ pop;

    unique case (state_q)
      S_LOAD: begin
        if (accept) begin
          wr_cnt_d = wr_cnt_q + CW'(1);
          if (wr_cnt_q == LAST) state_d = S_START;
        end
      end
      S_START: begin
        wait_cnt_d = 2'd0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // The first two cycles may still see the done level of the last frame.
        if (wait_cnt_q != 2'd2) wait_cnt_d = wait_cnt_q + 2'd1;
        else if (iRDY_CORE)     state_d    = S_UNLOAD;
      end
      default: begin
        if (issue) begin
          rd_cnt_d    = rd_cnt_q + CW'(1);
          addr_rd_d   = bitrev(rd_cnt_q[CW-1:2]);
          infl_d      = 1'b1;
          infl_bank_d = rd_cnt_q[1:0];
          if (rd_cnt_q == LAST) iss_done_d = 1'b1;
        end
        if (pop) begin
          pop_cnt_d = pop_cnt_q + CW'(1);
          if (pop_cnt_q == LAST) begin
            state_d    = S_LOAD;
            iss_done_d = 1'b0;
          end
        end
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q     <= S_LOAD;
      wr_cnt_q    <= '0;
      wait_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      iss_done_q  <= 1'b0;
      pop_cnt_q   <= '0;
      infl_q      <= 1'b0;
      infl_bank_q <= '0;
      addr_rd_q   <= '0;
      occ_q       <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      iss_done_q  <= iss_done_d;
      pop_cnt_q   <= pop_cnt_d;
      infl_q      <= infl_d;
      infl_bank_q <= infl_bank_d;
      addr_rd_q   <= addr_rd_d;
      occ_q       <= occ_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rdy_en_q    <= 1'b1;
    end
  end

  // Skid buffer storage; contents are only observed while occupancy says so.
  always_ff @(posedge iCLK) begin
    if (infl_q) buf_q[wptr_q] <= rd_data;
  end

  // Output decode.
  always_comb begin
    oREADY   = (state_q == S_LOAD) && rdy_en_q;
    oWE      = accept ? (4'b0001 << wr_cnt_q[1:0]) : 4'b0000;
    oADDR_WR = wr_cnt_q[CW-1:2];
    oDATA_WR = iDATA;
    oSTART   = (state_q == S_START);
    oADDR_RD = addr_rd_q;
    oVALID   = (occ_q != 2'd0);
    oDATA    = oVALID ? buf_q[rptr_q] : '0;
    oBUSY    = (state_q != S_LOAD) || (wr_cnt_q != '0) || accept;
  end

endmodule

// File: tb/tb_fht_frame_seq.sv
// Directed testbench for fht_frame_seq with A_BIT=2 (N=4, 16-word frames).
module tb_fht_frame_seq;
  localparam int D_BIT = 16;
  localparam int A_BIT = 2;
  localparam int N     = 4;
  localparam int F     = 16;

  logic             iCLK = 1'b0;
  logic             iRESET = 1'b0;
  logic             iVALID = 1'b0;
  logic [D_BIT-1:0] iDATA = '0;
  logic             oREADY;
  logic [3:0]       oWE;
  logic [A_BIT-1:0] oADDR_WR;
  logic [D_BIT-1:0] oDATA_WR;
  logic             oSTART;
  logic             iRDY_CORE = 1'b0;
  logic [A_BIT-1:0] oADDR_RD;
  logic [D_BIT-1:0] iDATA_RD_0, iDATA_RD_1, iDATA_RD_2, iDATA_RD_3;
  logic             oVALID;
  logic [D_BIT-1:0] oDATA;
  logic             iREADY = 1'b1;
  logic             oBUSY;

  int checks = 0;
  int errors = 0;

  // Expected output order for core RAM contents b[a] = 16*b + a.
  int exp_tab [16] = '{0, 16, 32, 48, 2, 18, 34, 50, 1, 17, 33, 49, 3, 19, 35, 51};

  fht_frame_seq #(.D_BIT(D_BIT), .A_BIT(A_BIT)) dut (
    .iCLK(iCLK), .iRESET(iRESET),
    .iVALID(iVALID), .iDATA(iDATA), .oREADY(oREADY),
    .oWE(oWE), .oADDR_WR(oADDR_WR), .oDATA_WR(oDATA_WR),
    .oSTART(oSTART), .iRDY_CORE(iRDY_CORE),
    .oADDR_RD(oADDR_RD),
    .iDATA_RD_0(iDATA_RD_0), .iDATA_RD_1(iDATA_RD_1),
    .iDATA_RD_2(iDATA_RD_2), .iDATA_RD_3(iDATA_RD_3),
    .oVALID(oVALID), .oDATA(oDATA), .iREADY(iREADY), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  // Core RAM model: synchronous write, read data follows the read address.
  logic [D_BIT-1:0] ram [4][N];
  always @(posedge iCLK) begin
    for (int b = 0; b < 4; b++)
      if (oWE[b]) ram[b][oADDR_WR] <= oDATA_WR;
  end
  assign iDATA_RD_0 = ram[0][oADDR_RD];
  assign iDATA_RD_1 = ram[1][oADDR_RD];
  assign iDATA_RD_2 = ram[2][oADDR_RD];
  assign iDATA_RD_3 = ram[3][oADDR_RD];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [D_BIT-1:0] samp(input int k, input int off);
    return D_BIT'(16 * (k % 4) + k / 4 + off);
  endfunction

  // Called at posedge+1 with the DUT in LOAD; returns at posedge+1 of the START cycle.
  task automatic load_frame(input int off, input bit gaps);
    logic [3:0] we_exp;
    for (int k = 0; k < F; k++) begin
      if (gaps && (k % 3 == 1)) begin
        iVALID    = 1'b0;
        iRDY_CORE = ~iRDY_CORE;
        @(negedge iCLK);
        check("gap_we", 32'(oWE), 0);
        @(posedge iCLK); #1;
      end
      iVALID = 1'b1;
      iDATA  = samp(k, off);
      we_exp = 4'b0001 << (k % 4);
      @(negedge iCLK);
      check("ld_ready", 32'(oREADY), 1);
      check("ld_we", 32'(oWE), 32'(we_exp));
      check("ld_addr", 32'(oADDR_WR), k / 4);
      check("ld_data", 32'(oDATA_WR), 32'(samp(k, off)));
      check("ld_busy", 32'(oBUSY), 1);
      @(posedge iCLK); #1;
    end
    iVALID = 1'b0;
  endtask

  // START cycle then n WAIT cycles, with iVALID optionally held high.
  task automatic start_wait(input int n, input bit vld);
    iVALID = vld;
    iDATA  = 16'hBEEF;
    @(negedge iCLK);
    check("start_pulse", 32'(oSTART), 1);
    check("start_ready", 32'(oREADY), 0);
    check("start_we", 32'(oWE), 0);
    @(posedge iCLK); #1;
    for (int i = 0; i < n; i++) begin
      @(negedge iCLK);
      check("wait_start", 32'(oSTART), 0);
      check("wait_we", 32'(oWE), 0);
      check("wait_ready", 32'(oREADY), 0);
      check("wait_valid", 32'(oVALID), 0);
      check("wait_busy", 32'(oBUSY), 1);
      @(posedge iCLK); #1;
    end
    iVALID = 1'b0;
  endtask

  // Consume up to 'limit' words; returns at posedge+1 after the last handshake.
  task automatic unload(input int off, input bit rnd, input int limit);
    int idx = 0;
    int cyc = 0;
    while (idx < limit && cyc < 300) begin
      iREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge iCLK);
      if (oVALID) begin
        check("ul_data", 32'(oDATA), 32'(exp_tab[idx] + off));
        check("ul_busy", 32'(oBUSY), 1);
        if (iREADY) idx++;
      end else if (!rnd && idx > 0) begin
        check("ul_bubble", 32'(oVALID), 1);
      end
      cyc++;
      @(posedge iCLK); #1;
    end
    if (idx < limit) check("ul_timeout", idx, limit);
    iREADY = 1'b1;
  endtask

  initial begin
    // Reset state
    iRESET = 1'b0;
    #2;
    check("rst_we", 32'(oWE), 0);
    check("rst_start", 32'(oSTART), 0);
    check("rst_valid", 32'(oVALID), 0);
    check("rst_busy", 32'(oBUSY), 0);
    check("rst_addr_wr", 32'(oADDR_WR), 0);
    check("rst_addr_rd", 32'(oADDR_RD), 0);
    check("rst_data", 32'(oDATA), 0);
    @(posedge iCLK); #1;
    iRESET = 1'b1;
    @(posedge iCLK); #1;
    check("rel_ready", 32'(oREADY), 1);
    check("rel_busy", 32'(oBUSY), 0);

    // Frame 1: back-to-back load, core ready held high, iREADY=1
    iRDY_CORE = 1'b1;
    load_frame(0, 1'b0);
    start_wait(3, 1'b0);
    unload(0, 1'b0, F);
    @(negedge iCLK);
    check("f1_busy_end", 32'(oBUSY), 0);
    check("f1_ready_end", 32'(oREADY), 1);
    check("f1_valid_end", 32'(oVALID), 0);
    @(posedge iCLK); #1;

    // Frame 2: load with gaps and core-ready toggling, iVALID during WAIT,
    // core done held off, random output back-pressure
    load_frame(8, 1'b1);
    iRDY_CORE = 1'b0;
    start_wait(6, 1'b1);
    iRDY_CORE = 1'b1;
    unload(8, 1'b1, F);
    @(negedge iCLK);
    check("f2_busy_end", 32'(oBUSY), 0);
    check("f2_ready_end", 32'(oREADY), 1);
    @(posedge iCLK); #1;

    // Frame 3: reset after five words of unload
    load_frame(32, 1'b0);
    start_wait(3, 1'b0);
    unload(32, 1'b0, 5);
    iRESET = 1'b0;
    #1;
    check("mrst_valid", 32'(oVALID), 0);
    check("mrst_data", 32'(oDATA), 0);
    check("mrst_busy", 32'(oBUSY), 0);
    check("mrst_start", 32'(oSTART), 0);
    check("mrst_we", 32'(oWE), 0);
    check("mrst_addr_rd", 32'(oADDR_RD), 0);
    check("mrst_addr_wr", 32'(oADDR_WR), 0);
    @(posedge iCLK); #1;
    iRESET = 1'b1;
    @(posedge iCLK); #1;
    check("mrst_ready", 32'(oREADY), 1);

    // Frame 4: fresh frame after reset
    load_frame(64, 1'b0);
    start_wait(3, 1'b0);
    unload(64, 1'b0, F);
    @(negedge iCLK);
    check("f4_busy_end", 32'(oBUSY), 0);
    check("f4_valid_end", 32'(oVALID), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
